vc_output_arbiter: RTL and testbench

- Per-output-port scheduler for the chiplet switch. It shares one physical output link between NUM_VCS virtual channels using downstream credit counters and round-robin arbitration.
- Wormhole lock: once a VC's head flit wins, that VC owns the link until its tail flit is sent.
- Sits between the per-VC output buffers and the link driver. It consumes the per-VC credit-return pulses from the neighbouring switch or endpoint.

---
 rtl/vc_output_arbiter_if.sv | 31 +++
 rtl/vc_output_arbiter.sv | 132 +++++++++++++
 tb/tb_vc_output_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vc_output_arbiter_if.sv
// Link-side bundle between the per-VC output buffers, the output arbiter
// and the downstream credit-return path of one switch output port.
interface vc_output_arbiter_if #(
  parameter int unsigned NUM_VCS     = 2,
  parameter int unsigned BUFFER_SIZE = 8
);
  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  logic [NUM_VCS-1:0]       req;
  logic [NUM_VCS-1:0]       head;
  logic [NUM_VCS-1:0]       tail;
  logic                     link_ready;
  logic [NUM_VCS-1:0]       credit_granted;
  logic [NUM_VCS-1:0]       grant;
  logic                     send;
  logic [NUM_VCS*CNT_W-1:0] credits;
  logic                     lock_valid;
  logic [VC_W-1:0]          locked_vc;
  logic                     credit_err;

  modport master (
    output req, head, tail, link_ready, credit_granted,
    input  grant, send, credits, lock_valid, locked_vc, credit_err
  );

  modport slave (
    input  req, head, tail, link_ready, credit_granted,
    output grant, send, credits, lock_valid, locked_vc, credit_err
  );
endinterface

// File: rtl/vc_output_arbiter.sv
// Output-port scheduler: credit-based, round-robin VC arbitration with a
// wormhole lock that holds the link for a VC until its tail flit is sent.
module vc_output_arbiter #(
  parameter int unsigned NUM_VCS     = 2,
  parameter int unsigned BUFFER_SIZE = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  vc_output_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUFFER_SIZE);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [VC_W-1:0]          locked_vc_q, locked_vc_d;
  logic [VC_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]         cnt_q [NUM_VCS];
  logic [CNT_W-1:0]         cnt_d [NUM_VCS];
  logic                     err_q, err_d;
  logic [NUM_VCS-1:0]       elig;
  logic [NUM_VCS-1:0]       grant_c;
  logic [VC_W-1:0]          gnt_idx;
  logic                     gnt_any;
  logic [NUM_VCS*CNT_W-1:0] credits_flat;
  int unsigned              scan_idx;

  // Under a lock only the owner may go, and it ignores the head bit.
  always_comb begin
    elig = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      elig[v] = bus.req[v] & bus.link_ready & (cnt_q[v] != '0) &
                ((state_q == LOCKED) ? (VC_W'(v) == locked_vc_q) : bus.head[v]);
    end
  end

  // Zero-latency grant: owner when locked, else first eligible from rr_ptr.
  always_comb begin
    grant_c  = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = 0;
    if (state_q == LOCKED) begin
      if (elig[locked_vc_q]) begin
        grant_c[locked_vc_q] = 1'b1;
        gnt_idx              = locked_vc_q;
        gnt_any              = 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_VCS; i++) begin
        scan_idx = 32'(rr_ptr_q) + i;
        if (scan_idx >= NUM_VCS) scan_idx = scan_idx - NUM_VCS;
        if (!gnt_any && elig[VC_W'(scan_idx)]) begin
          grant_c[VC_W'(scan_idx)] = 1'b1;
          gnt_idx                  = VC_W'(scan_idx);
          gnt_any                  = 1'b1;
        end
      end
    end
  end

  // Lock FSM and round-robin pointer; the pointer moves only on packet completion.
  always_comb begin
    state_d     = state_q;
    locked_vc_d = locked_vc_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_any && bus.head[gnt_idx] && !bus.tail[gnt_idx]) begin
          state_d     = LOCKED;
          locked_vc_d = gnt_idx;
        end
      end
      LOCKED: begin
        if (gnt_any && bus.tail[gnt_idx]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (gnt_any && bus.tail[gnt_idx]) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_VCS - 1) ? '0 : gnt_idx + VC_W'(1);
    end
  end

  // Credit counters; a return that would exceed the buffer depth is dropped and flagged.
  always_comb begin
    err_d = err_q;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      cnt_d[v] = cnt_q[v];
      case ({grant_c[v], bus.credit_granted[v]})
        2'b10: cnt_d[v] = cnt_q[v] - CNT_W'(1);
        2'b01: begin
          if (cnt_q[v] == CNT_MAX) err_d = 1'b1;
          else                     cnt_d[v] = cnt_q[v] + CNT_W'(1);
        end
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      locked_vc_q <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
      for (int unsigned v = 0; v < NUM_VCS; v++) cnt_q[v] <= CNT_MAX;
    end else begin
      state_q     <= state_d;
      locked_vc_q <= locked_vc_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
      for (int unsigned v = 0; v < NUM_VCS; v++) cnt_q[v] <= cnt_d[v];
    end
  end

  always_comb begin
    credits_flat = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      credits_flat[v*CNT_W +: CNT_W] = cnt_q[v];
    end
  end

  assign bus.grant      = grant_c;
  assign bus.send       = gnt_any;
  assign bus.credits    = credits_flat;
  assign bus.lock_valid = (state_q == LOCKED);
  assign bus.locked_vc  = locked_vc_q;
  assign bus.credit_err = err_q;

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Bench for vc_output_arbiter: directed scenarios plus random packet traffic,
// all checked against a packet-level reference model of the scheduler.
module tb_vc_output_arbiter;
  localparam int NV = 2;
  localparam int BS = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  vc_output_arbiter_if #(.NUM_VCS(NV), .BUFFER_SIZE(BS)) bus ();
  vc_output_arbiter #(.NUM_VCS(NV), .BUFFER_SIZE(BS)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: credits, current wormhole owner (-1 = none), rr start, sticky error.
  int m_cred [NV];
  int m_owner;
  int m_rr;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) m_cred[v] = BS;
    m_owner = -1;
    m_rr    = 0;
    m_err   = 1'b0;
  endfunction

  function automatic logic [NV-1:0] model_grant(input logic [NV-1:0] r, input logic [NV-1:0] h,
                                               input logic lr);
    logic [NV-1:0] g;
    g = '0;
    if (!lr) return g;
    if (m_owner >= 0) begin
      if (r[m_owner] && m_cred[m_owner] > 0) g[m_owner] = 1'b1;
    end else begin
      for (int i = 0; i < NV; i++) begin
        int v;
        v = (m_rr + i) % NV;
        if (g == '0 && r[v] && h[v] && m_cred[v] > 0) g[v] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic void model_update(input logic [NV-1:0] g, input logic [NV-1:0] h,
                                       input logic [NV-1:0] t, input logic [NV-1:0] cg);
    for (int v = 0; v < NV; v++) begin
      if (g[v] && cg[v]) begin
      end else if (g[v]) begin
        m_cred[v]--;
      end else if (cg[v]) begin
        if (m_cred[v] == BS) m_err = 1'b1;
        else                 m_cred[v]++;
      end
      if (g[v]) begin
        if (m_owner < 0 && h[v] && !t[v]) m_owner = v;
        if (t[v]) begin
          m_owner = -1;
          m_rr    = (v + 1) % NV;
        end
      end
    end
  endfunction

  // One clock cycle: drive at negedge, compare combinational and state outputs, advance model.
  task automatic step(input logic [NV-1:0] r, input logic [NV-1:0] h, input logic [NV-1:0] t,
                      input logic [NV-1:0] cg, input logic lr,
                      output logic [NV-1:0] eg, output logic [NV-1:0] og);
    @(negedge clk);
    bus.req            = r;
    bus.head           = h;
    bus.tail           = t;
    bus.credit_granted = cg;
    bus.link_ready     = lr;
    #1;
    eg = model_grant(r, h, lr);
    og = bus.grant;
    check("grant", 32'(og), 32'(eg));
    check("send", 32'(bus.send), 32'(|eg));
    for (int v = 0; v < NV; v++) check("credits", 32'(bus.credits[v*CW +: CW]), 32'(m_cred[v]));
    check("lock_valid", 32'(bus.lock_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) check("locked_vc", 32'(bus.locked_vc), 32'(m_owner));
    check("credit_err", 32'(bus.credit_err), 32'(m_err));
    @(posedge clk);
    model_update(eg, h, t, cg);
  endtask

  logic [NV-1:0] eg, og, pg;
  int pkt_len [NV];
  int pkt_pos [NV];

  initial begin
    n_rst              = 1'b0;
    bus.req            = '0;
    bus.head           = '0;
    bus.tail           = '0;
    bus.credit_granted = '0;
    bus.link_ready     = 1'b1;
    model_reset();

    // Reset state
    #12;
    check("rst_credits0", 32'(bus.credits[0 +: CW]), 8);
    check("rst_credits1", 32'(bus.credits[CW +: CW]), 8);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_lock", 32'(bus.lock_valid), 0);
    check("rst_err", 32'(bus.credit_err), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Single-flit packets on both VCs alternate starting at VC0
    pg = '0;
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b11, 2'b11, pg, 1'b1, eg, og);
      check("alt_grant", 32'(og), (k % 2 == 0) ? 32'd1 : 32'd2);
      pg = eg;
    end

    // 3-flit packet on VC0 holds the link while VC1 waits
    step(2'b11, 2'b11, 2'b10, pg, 1'b1, eg, og); check("pkt_f1", 32'(og), 1); pg = eg;
    step(2'b11, 2'b10, 2'b10, pg, 1'b1, eg, og); check("pkt_f2", 32'(og), 1); pg = eg;
    check("pkt_lock", 32'(bus.lock_valid), 1);
    step(2'b11, 2'b10, 2'b11, pg, 1'b1, eg, og); check("pkt_f3", 32'(og), 1); pg = eg;
    step(2'b10, 2'b10, 2'b10, pg, 1'b1, eg, og); check("pkt_vc1", 32'(og), 2); pg = eg;
    step(2'b00, 2'b00, 2'b00, pg, 1'b1, eg, og);

    // VC0 drains all credits, then one returned credit lets it go a cycle later
    for (int k = 0; k < 8; k++) begin
      step(2'b01, (k == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00, 1'b1, eg, og);
      check("drain_grant", 32'(og), 1);
    end
    step(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, eg, og); check("empty_grant", 32'(og), 0);
    step(2'b01, 2'b00, 2'b01, 2'b01, 1'b1, eg, og); check("ret_same_cyc", 32'(og), 0);
    step(2'b01, 2'b00, 2'b01, 2'b00, 1'b1, eg, og); check("ret_next_cyc", 32'(og), 1);
    for (int k = 0; k < 8; k++) step(2'b00, 2'b00, 2'b00, 2'b01, 1'b1, eg, og);

    // Grant and credit return in the same cycle; overflow sets a sticky error
    step(2'b10, 2'b10, 2'b10, 2'b00, 1'b1, eg, og);
    step(2'b10, 2'b10, 2'b10, 2'b10, 1'b1, eg, og); check("both_grant", 32'(og), 2);
    #1;
    check("both_credits1", 32'(bus.credits[CW +: CW]), 7);
    step(2'b00, 2'b00, 2'b00, 2'b10, 1'b1, eg, og);
    step(2'b00, 2'b00, 2'b00, 2'b01, 1'b1, eg, og);
    #1;
    check("ovf_credits0", 32'(bus.credits[0 +: CW]), 8);
    check("ovf_err", 32'(bus.credit_err), 1);
    for (int k = 0; k < 3; k++) step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, eg, og);

    // Asynchronous reset in the middle of a locked packet
    step(2'b01, 2'b01, 2'b00, 2'b00, 1'b1, eg, og);
    for (int k = 0; k < 4; k++) step(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, eg, og);
    #1;
    check("pre_rst_lock", 32'(bus.lock_valid), 1);
    check("pre_rst_credits0", 32'(bus.credits[0 +: CW]), 3);
    #1;
    n_rst = 1'b0;
    #1;
    check("async_rst_lock", 32'(bus.lock_valid), 0);
    check("async_rst_credits0", 32'(bus.credits[0 +: CW]), 8);
    check("async_rst_err", 32'(bus.credit_err), 0);
    model_reset();
    @(negedge clk);
    bus.req            = '0;
    bus.head           = '0;
    bus.tail           = '0;
    bus.credit_granted = '0;
    n_rst              = 1'b1;

    // Random packet traffic with realistic credit returns
    for (int v = 0; v < NV; v++) begin
      pkt_len[v] = 0;
      pkt_pos[v] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      logic [NV-1:0] r, h, t, cg;
      logic lr;
      for (int v = 0; v < NV; v++) begin
        if (pkt_len[v] == 0) begin
          pkt_len[v] = int'($urandom_range(1, 4));
          pkt_pos[v] = 0;
        end
        r[v]  = ($urandom_range(0, 3) != 0);
        h[v]  = (pkt_pos[v] == 0);
        t[v]  = (pkt_pos[v] == pkt_len[v] - 1);
        cg[v] = (m_cred[v] < BS) && ($urandom_range(0, 2) == 0);
      end
      lr = ($urandom_range(0, 9) < 8);
      step(r, h, t, cg, lr, eg, og);
      for (int v = 0; v < NV; v++) begin
        if (eg[v]) begin
          pkt_pos[v]++;
          if (pkt_pos[v] == pkt_len[v]) pkt_len[v] = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
